// File: rtl/rtc_calendar.sv
`default_nettype none
// ============================================================================
// Module   : rtc_calendar
// Brief    : Prescaled hh:mm:ss / yy-mm-dd clock-calendar with validated
//            load, 12/24-hour display and per-channel alarm comparators.
// Revision : 1.0
// ============================================================================
module rtc_calendar #(
  parameter int TICK_DIV   = 100000,
  parameter int ALARM_CH   = 2,
  parameter int RESET_YEAR = 16
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  RUN,
  input  logic                  LOAD,
  input  logic [16:0]           LOAD_TIME,
  input  logic [15:0]           LOAD_DATE,
  input  logic                  HOUR12,
  input  logic [17*ALARM_CH-1:0] ALARM_TIME,
  input  logic [ALARM_CH-1:0]   ALARM_EN,
  output logic [16:0]           TIME_OUT,
  output logic [15:0]           DATE_OUT,
  output logic                  PM,
  output logic                  TICK,
  output logic                  LOAD_OK,
  output logic                  LOAD_ERR,
  output logic [ALARM_CH-1:0]   ALARM_HIT
);

  localparam int             c_PW         = $clog2(TICK_DIV);
  localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(TICK_DIV - 1);

  function automatic logic [4:0] f_days_in_month(input logic [3:0] month,
                                                 input logic [6:0] year);
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: f_days_in_month = 5'd30;
      4'd2:                    f_days_in_month = (year[1:0] == 2'd0) ? 5'd29 : 5'd28;
      default:                 f_days_in_month = 5'd31;
    endcase
  endfunction

  logic [c_PW-1:0]     r_presc;
  logic [4:0]          r_hour;
  logic [5:0]          r_min;
  logic [5:0]          r_sec;
  logic [6:0]          r_year;
  logic [3:0]          r_month;
  logic [4:0]          r_day;
  logic                r_pm;
  logic                r_tick;
  logic                r_load_ok;
  logic                r_load_err;
  logic [ALARM_CH-1:0] r_alarm_hit;

  logic [4:0]  w_ld_hour;
  logic [5:0]  w_ld_min;
  logic [5:0]  w_ld_sec;
  logic [6:0]  w_ld_year;
  logic [3:0]  w_ld_month;
  logic [4:0]  w_ld_day;
  logic        w_load_valid;
  logic        w_presc_last;

  logic [4:0]  w_n_hour;
  logic [5:0]  w_n_min;
  logic [5:0]  w_n_sec;
  logic [6:0]  w_n_year;
  logic [3:0]  w_n_month;
  logic [4:0]  w_n_day;
  logic [16:0] w_next_time;
  logic [ALARM_CH-1:0] w_match;
  logic [4:0]  w_disp_hour;

  assign w_ld_hour  = LOAD_TIME[16:12];
  assign w_ld_min   = LOAD_TIME[11:6];
  assign w_ld_sec   = LOAD_TIME[5:0];
  assign w_ld_year  = LOAD_DATE[15:9];
  assign w_ld_month = LOAD_DATE[8:5];
  assign w_ld_day   = LOAD_DATE[4:0];

  assign w_load_valid = (w_ld_hour <= 5'd23) && (w_ld_min <= 6'd59) && (w_ld_sec <= 6'd59) &&
                        (w_ld_month >= 4'd1) && (w_ld_month <= 4'd12) &&
                        (w_ld_day >= 5'd1) &&
                        (w_ld_day <= f_days_in_month(w_ld_month, w_ld_year)) &&
                        (w_ld_year <= 7'd99);

  assign w_presc_last = (r_presc == c_PRESC_MAX);

  // Full carry chain from seconds through year, resolved in a single edge
  always_comb begin
    w_n_sec   = r_sec + 6'd1;
    w_n_min   = r_min;
    w_n_hour  = r_hour;
    w_n_day   = r_day;
    w_n_month = r_month;
    w_n_year  = r_year;
    if (r_sec == 6'd59) begin
      w_n_sec = 6'd0;
      if (r_min == 6'd59) begin
        w_n_min = 6'd0;
        if (r_hour == 5'd23) begin
          w_n_hour = 5'd0;
          if (r_day == f_days_in_month(r_month, r_year)) begin
            w_n_day = 5'd1;
            if (r_month == 4'd12) begin
              w_n_month = 4'd1;
              w_n_year  = (r_year == 7'd99) ? 7'd0 : r_year + 7'd1;
            end else begin
              w_n_month = r_month + 4'd1;
            end
          end else begin
            w_n_day = r_day + 5'd1;
          end
        end else begin
          w_n_hour = r_hour + 5'd1;
        end
      end else begin
        w_n_min = r_min + 6'd1;
      end
    end
  end

  assign w_next_time = {w_n_hour, w_n_min, w_n_sec};

  // The running time is always in range, so an out-of-range alarm can never match
  generate
    for (genvar k = 0; k < ALARM_CH; k++) begin : g_alarm
      assign w_match[k] = ALARM_EN[k] && (ALARM_TIME[17*k +: 17] == w_next_time);
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_presc     <= '0;
      r_hour      <= 5'd0;
      r_min       <= 6'd0;
      r_sec       <= 6'd0;
      r_year      <= 7'(RESET_YEAR);
      r_month     <= 4'd1;
      r_day       <= 5'd1;
      r_pm        <= 1'b0;
      r_tick      <= 1'b0;
      r_load_ok   <= 1'b0;
      r_load_err  <= 1'b0;
      r_alarm_hit <= '0;
    end else begin
      r_tick      <= 1'b0;
      r_load_ok   <= 1'b0;
      r_load_err  <= 1'b0;
      r_alarm_hit <= '0;
      if (LOAD && w_load_valid) begin
        r_presc   <= '0;
        r_hour    <= w_ld_hour;
        r_min     <= w_ld_min;
        r_sec     <= w_ld_sec;
        r_year    <= w_ld_year;
        r_month   <= w_ld_month;
        r_day     <= w_ld_day;
        r_pm      <= (w_ld_hour >= 5'd12);
        r_load_ok <= 1'b1;
      end else begin
        r_load_err <= LOAD;
        if (RUN) begin
          if (w_presc_last) begin
            r_presc     <= '0;
            r_hour      <= w_n_hour;
            r_min       <= w_n_min;
            r_sec       <= w_n_sec;
            r_year      <= w_n_year;
            r_month     <= w_n_month;
            r_day       <= w_n_day;
            r_pm        <= (w_n_hour >= 5'd12);
            r_tick      <= 1'b1;
            r_alarm_hit <= w_match;
          end else begin
            r_presc <= r_presc + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    w_disp_hour = r_hour;
    if (HOUR12) begin
      if (r_hour == 5'd0)
        w_disp_hour = 5'd12;
      else if (r_hour > 5'd12)
        w_disp_hour = r_hour - 5'd12;
    end
  end

  assign TIME_OUT  = {w_disp_hour, r_min, r_sec};
  assign DATE_OUT  = {r_year, r_month, r_day};
  assign PM        = r_pm;
  assign TICK      = r_tick;
  assign LOAD_OK   = r_load_ok;
  assign LOAD_ERR  = r_load_err;
  assign ALARM_HIT = r_alarm_hit;

endmodule
`default_nettype wire

// File: tb/tb_rtc_calendar.sv
`default_nettype none
// ============================================================================
// Module   : tb_rtc_calendar
// Brief    : Directed self-checking bench for rtc_calendar (TICK_DIV=4).
// Revision : 1.0
// ============================================================================
module tb_rtc_calendar;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic        RUN;
  logic        LOAD;
  logic [16:0] LOAD_TIME;
  logic [15:0] LOAD_DATE;
  logic        HOUR12;
  logic [33:0] ALARM_TIME;
  logic [1:0]  ALARM_EN;
  logic [16:0] TIME_OUT;
  logic [15:0] DATE_OUT;
  logic        PM;
  logic        TICK;
  logic        LOAD_OK;
  logic        LOAD_ERR;
  logic [1:0]  ALARM_HIT;

  int n_tests = 0;
  int n_fail  = 0;
  int n_ticks;

  rtc_calendar #(.TICK_DIV(4), .ALARM_CH(2), .RESET_YEAR(16)) dut (
    .CLK(CLK), .RESETN(RESETN), .RUN(RUN), .LOAD(LOAD),
    .LOAD_TIME(LOAD_TIME), .LOAD_DATE(LOAD_DATE), .HOUR12(HOUR12),
    .ALARM_TIME(ALARM_TIME), .ALARM_EN(ALARM_EN),
    .TIME_OUT(TIME_OUT), .DATE_OUT(DATE_OUT), .PM(PM), .TICK(TICK),
    .LOAD_OK(LOAD_OK), .LOAD_ERR(LOAD_ERR), .ALARM_HIT(ALARM_HIT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [16:0] tm(input int h, input int m, input int s);
    tm = {5'(h), 6'(m), 6'(s)};
  endfunction

  function automatic logic [15:0] dt(input int y, input int mo, input int d);
    dt = {7'(y), 4'(mo), 5'(d)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_load(input int y, input int mo, input int d,
                         input int h, input int m, input int s);
    LOAD_DATE = dt(y, mo, d);
    LOAD_TIME = tm(h, m, s);
    LOAD      = 1'b1;
    step();
    LOAD      = 1'b0;
  endtask

  // After a load the prescaler is 0: three quiet edges, then the tick edge
  task automatic run_to_tick(input string tag);
    step();
    step();
    step();
    chk({tag, "_pre_tick"}, TICK, 0);
    step();
    chk({tag, "_tick"}, TICK, 1);
  endtask

  initial begin
    RESETN     = 1'b0;
    RUN        = 1'b1;
    LOAD       = 1'b0;
    LOAD_TIME  = '0;
    LOAD_DATE  = '0;
    HOUR12     = 1'b0;
    ALARM_EN   = 2'b00;
    ALARM_TIME = {tm(7, 0, 0), tm(7, 0, 0)};
    step();
    step();

    // Reset state
    chk("rst_time", TIME_OUT, tm(0, 0, 0));
    chk("rst_date", DATE_OUT, dt(16, 1, 1));
    chk("rst_pulses", {TICK, LOAD_OK, LOAD_ERR, ALARM_HIT, PM}, 0);
    HOUR12 = 1'b1;
    #1;
    chk("rst_time_12h", TIME_OUT, tm(12, 0, 0));
    HOUR12 = 1'b0;
    RESETN = 1'b1;

    // Leap-year February
    do_load(16, 2, 28, 23, 59, 59);
    chk("t1_load_ok", {LOAD_OK, LOAD_ERR}, 2'b10);
    step();
    chk("t1_load_ok_gone", LOAD_OK, 0);
    step();
    step();
    chk("t1_pre_tick", TICK, 0);
    step();
    chk("t1_tick", TICK, 1);
    chk("t1_date", DATE_OUT, dt(16, 2, 29));
    chk("t1_time", TIME_OUT, tm(0, 0, 0));

    // Non-leap February, 30-day month and century wrap
    do_load(17, 2, 28, 23, 59, 59);
    run_to_tick("t2a");
    chk("t2a_date", DATE_OUT, dt(17, 3, 1));
    chk("t2a_time", TIME_OUT, tm(0, 0, 0));
    do_load(16, 4, 30, 23, 59, 59);
    run_to_tick("t2b");
    chk("t2b_date", DATE_OUT, dt(16, 5, 1));
    do_load(99, 12, 31, 23, 59, 59);
    run_to_tick("t2c");
    chk("t2c_date", DATE_OUT, dt(0, 1, 1));
    chk("t2c_time", TIME_OUT, tm(0, 0, 0));

    // Invalid loads leave state untouched
    do_load(17, 2, 29, 10, 0, 0);
    chk("t3_feb29", {LOAD_OK, LOAD_ERR}, 2'b01);
    chk("t3_time_kept", TIME_OUT, tm(0, 0, 0));
    chk("t3_date_kept", DATE_OUT, dt(0, 1, 1));
    do_load(16, 1, 1, 24, 0, 0);
    chk("t3_hour24", {LOAD_OK, LOAD_ERR}, 2'b01);
    do_load(16, 13, 1, 0, 0, 0);
    chk("t3_month13", {LOAD_OK, LOAD_ERR}, 2'b01);

    // Alarms
    ALARM_EN = 2'b01;
    do_load(16, 5, 1, 6, 59, 59);
    chk("t4_load_nohit", ALARM_HIT, 2'b00);
    run_to_tick("t4a");
    chk("t4a_time", TIME_OUT, tm(7, 0, 0));
    chk("t4a_hit", ALARM_HIT, 2'b01);
    step();
    chk("t4a_hit_gone", ALARM_HIT, 2'b00);
    ALARM_EN = 2'b11;
    do_load(16, 5, 1, 6, 59, 59);
    run_to_tick("t4b");
    chk("t4b_hit_both", ALARM_HIT, 2'b11);
    do_load(16, 5, 1, 7, 0, 0);
    chk("t4c_load_on_alarm", ALARM_HIT, 2'b00);
    run_to_tick("t4c");
    chk("t4c_no_hit", ALARM_HIT, 2'b00);

    // 12-hour display
    HOUR12 = 1'b1;
    do_load(16, 5, 1, 0, 15, 0);
    chk("t5_midnight", {PM, TIME_OUT}, {1'b0, tm(12, 15, 0)});
    do_load(16, 5, 1, 12, 0, 0);
    chk("t5_noon", {PM, TIME_OUT}, {1'b1, tm(12, 0, 0)});
    do_load(16, 5, 1, 13, 5, 0);
    chk("t5_1pm", {PM, TIME_OUT}, {1'b1, tm(1, 5, 0)});
    HOUR12 = 1'b0;
    #1;
    chk("t5_24h", {PM, TIME_OUT}, {1'b1, tm(13, 5, 0)});

    // Load in the tick cycle wins and restarts the prescaler
    do_load(16, 6, 1, 10, 0, 0);
    step();
    step();
    step();
    do_load(16, 6, 1, 11, 22, 33);
    chk("t6_load_prio", {TICK, LOAD_OK}, 2'b01);
    chk("t6_load_time", TIME_OUT, tm(11, 22, 33));
    run_to_tick("t6a");
    chk("t6a_time", TIME_OUT, tm(11, 22, 34));
    // Rejected load in the tick cycle still ticks
    step();
    step();
    step();
    do_load(16, 6, 1, 24, 0, 0);
    chk("t6_rej_tick", {TICK, LOAD_ERR, LOAD_OK}, 3'b110);
    chk("t6_rej_time", TIME_OUT, tm(11, 22, 35));

    // Reset mid-count
    step();
    step();
    RESETN = 1'b0;
    step();
    chk("t6_rst_time", TIME_OUT, tm(0, 0, 0));
    chk("t6_rst_date", DATE_OUT, dt(16, 1, 1));
    chk("t6_rst_pulses", {TICK, LOAD_OK, LOAD_ERR, ALARM_HIT}, 0);
    RESETN = 1'b1;

    // RUN=0 freezes the prescaler without restarting it
    step();
    step();
    RUN     = 1'b0;
    n_ticks = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (TICK) n_ticks++;
    end
    chk("t6_frozen_ticks", n_ticks, 0);
    chk("t6_frozen_time", TIME_OUT, tm(0, 0, 0));
    RUN = 1'b1;
    step();
    chk("t6_resume_pre", TICK, 0);
    step();
    chk("t6_resume_tick", TICK, 1);
    chk("t6_resume_time", TIME_OUT, tm(0, 0, 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
